// File: rtl/i2c_slave_pkg.sv
// Shared FSM state type, bus ACK/NACK levels and default address for the I2C slave core.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

    localparam logic       I2C_ACK            = 1'b0;
    localparam logic       I2C_NACK           = 1'b1;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP condition decode.
module i2c_bus_sync
    import i2c_slave_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_dly_q;
    logic       sda_dly_q;
    logic       scl_s;
    logic       sda_s;

    // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of its predecessor.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_dly_q  <= scl_sync_q[1];
            sda_dly_q  <= sda_sync_q[1];
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_dly_q;
    assign scl_fall_o = ~scl_s & scl_dly_q;
    // SCL must be high on both samples so a simultaneous SCL/SDA change is not taken as a condition.
    assign start_o    = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_o     = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C slave byte engine: address match, write receive, read transmit.
// Optional SCL clock stretching while waiting for a tx byte: define I2C_SLAVE_CLOCK_STRETCH_EN.
module i2c_slave_core
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       scl_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o
);

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    localparam logic STRETCH_EN = 1'b1;
`else
    localparam logic STRETCH_EN = 1'b0;
`endif

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    i2c_bus_sync u_bus_sync (
        .clk_i      (i2c_core_clock_i),
        .rst_n_i    (reset_bit_n_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    state_e     state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic       done_q,     done_d;
    logic [7:0] shift_q,    shift_d;
    logic       rw_q,       rw_d;
    logic       sda_oe_q,   sda_oe_d;
    logic       scl_oe_q,   scl_oe_d;
    logic       stretch_q,  stretch_d;
    logic       busy_q,     busy_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ready_q, tx_ready_d;
    logic       load_tx;

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            done_q     <= 1'b0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            stretch_q  <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            stretch_q  <= stretch_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = done_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        scl_oe_d   = scl_oe_q;
        stretch_d  = stretch_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = 1'b0;
        load_tx    = 1'b0;

        if (bus_stop) begin
            state_d   = ST_IDLE;
            done_d    = 1'b0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            stretch_d = 1'b0;
            busy_d    = 1'b0;
        end else if (bus_start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            done_d    = 1'b0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            stretch_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_WAIT_STOP: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = sda_s;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // done_q marks the ACK slot as being driven; the second fall ends it.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!done_q) begin
                            sda_oe_d = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            done_d    = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (rw_q) begin
                                state_d = ST_TX_DATA;
                                load_tx = 1'b1;
                            end else begin
                                state_d  = ST_RX_DATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                        end
                    end else if (scl_fall && done_q) begin
                        state_d  = ST_RX_ACK;
                        sda_oe_d = 1'b1;
                        done_d   = 1'b0;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_RX_DATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_TX_DATA: begin
                    if (stretch_q) begin
                        if (tx_valid_i) begin
                            shift_d    = tx_data_i;
                            tx_ready_d = 1'b1;
                            sda_oe_d   = ~tx_data_i[7];
                            stretch_d  = 1'b0;
                        end
                    end else begin
                        // SCL is let go one cycle after the first bit is already on SDA.
                        if (scl_oe_q) begin
                            scl_oe_d = 1'b0;
                        end
                        if (scl_fall) begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_d  = ST_TX_ACK;
                                sda_oe_d = 1'b0;
                            end else begin
                                shift_d  = {shift_q[6:0], 1'b0};
                                sda_oe_d = ~shift_q[6];
                            end
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall && done_q) begin
                        state_d   = ST_TX_DATA;
                        done_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        load_tx   = 1'b1;
                    end
                end
            endcase

            if (load_tx) begin
                if (tx_valid_i) begin
                    shift_d    = tx_data_i;
                    tx_ready_d = 1'b1;
                    sda_oe_d   = ~tx_data_i[7];
                end else if (STRETCH_EN) begin
                    stretch_d = 1'b1;
                    scl_oe_d  = 1'b1;
                    sda_oe_d  = 1'b0;
                end else begin
                    shift_d  = 8'hFF;
                    sda_oe_d = 1'b0;
                end
            end
        end
    end

    assign sda_oe_o   = sda_oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = tx_ready_q;
    assign busy_o     = busy_q;

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    assign scl_oe_o = scl_oe_q;
`else
    assign scl_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-level I2C master on a wired-AND bus plus a transaction-level expectation model.
module tb_i2c_slave_core;
    import i2c_slave_pkg::*;

    localparam int         Q       = 4;
    localparam logic [6:0] MY_ADDR = 7'h3C;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
    localparam logic STRETCH = 1'b1;
`else
    localparam logic STRETCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m;
    logic       scl_line, sda_line;
    logic       sda_oe, scl_oe, rx_valid, tx_ready, busy, tx_valid;
    logic [7:0] rx_data, tx_data;

    always #5 clk = ~clk;

    assign scl_line = scl_m & ~scl_oe;
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_core #(.SLAVE_ADDR(MY_ADDR)) dut (
        .i2c_core_clock_i (clk),
        .reset_bit_n_i    (rst_n),
        .scl_i            (scl_line),
        .sda_i            (sda_line),
        .sda_oe_o         (sda_oe),
        .scl_oe_o         (scl_oe),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .busy_o           (busy)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] rx_q[$];
    int         txr_cnt   = 0;
    int         oe_cyc    = 0;
    int         oe_glitch = 0;
    int         busy_low  = 0;
    logic       busy_watch = 1'b0;
    logic       prev_oe    = 1'b0;

    // Bus observer: captured bytes, handshake pulses, and SDA drive changes while SCL is high.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
        if (tx_ready === 1'b1) txr_cnt++;
        if (sda_oe === 1'b1) oe_cyc++;
        if (sda_oe !== prev_oe && scl_line === 1'b1 && rst_n === 1'b1) oe_glitch++;
        prev_oe = sda_oe;
        if (busy_watch && busy !== 1'b1) busy_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raise_scl();
        scl_m = 1'b1;
        for (int n = 0; n < 400 && scl_line !== 1'b1; n++) @(negedge clk);
        if (scl_line !== 1'b1) check("scl_release_timeout", 32'(scl_line), 32'd1);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        tick(Q); raise_scl(); tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        tick(Q); raise_scl(); tick(Q);
        b = sda_line;
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic send_start();
        sda_m = 1'b1;
        tick(Q); raise_scl(); tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic send_stop();
        sda_m = 1'b0;
        tick(Q); raise_scl(); tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
    endtask

    function automatic logic [7:0] rx_at(input int k);
        return (k < rx_q.size()) ? rx_q[k] : 8'hxx;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, seen, match, rw;
        logic [7:0] b, b2;
        logic [6:0] a;
        logic [7:0] dat[3];
        int         n, scl_cnt, exp_n;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_valid = 1'b1; tx_data = 8'h00;
        tick(3);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_scl_oe",   32'(scl_oe),   32'd0);
        check("rst_rx_data",  32'(rx_data),  32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        rst_n = 1'b1;
        tick(5);

        // Write 0xA5 to our address.
        rx_q.delete();
        send_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        check("wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        check("wr_busy", 32'(busy), 32'd1);
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'(I2C_ACK));
        send_stop(); tick(Q);
        check("wr_rx_count", 32'(rx_q.size()), 32'd1);
        check("wr_rx_byte", 32'(rx_at(0)), 32'hA5);
        check("wr_rx_data_port", 32'(rx_data), 32'hA5);
        check("wr_busy_after_stop", 32'(busy), 32'd0);
        check("wr_sda_released", 32'(sda_oe), 32'd0);

        // Foreign address: the slave must never touch SDA.
        rx_q.delete(); oe_cyc = 0;
        send_start();
        write_byte({7'h3D, 1'b0}, ack);
        check("foreign_addr_nack", 32'(ack), 32'(I2C_NACK));
        write_byte(8'h5C, ack);
        check("foreign_data_nack", 32'(ack), 32'(I2C_NACK));
        check("foreign_busy", 32'(busy), 32'd0);
        send_stop(); tick(Q);
        check("foreign_oe_cycles", 32'(oe_cyc), 32'd0);
        check("foreign_rx_count", 32'(rx_q.size()), 32'd0);

        // Read two bytes, ACK the first and NACK the second.
        txr_cnt = 0; tx_data = 8'h5A; tx_valid = 1'b1;
        send_start();
        write_byte({MY_ADDR, 1'b1}, ack);
        check("rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        read_byte(b);
        tx_data = 8'hC3;
        write_bit(I2C_ACK);
        read_byte(b2);
        write_bit(I2C_NACK);
        check("rd_sda_released_after_nack", 32'(sda_oe), 32'd0);
        send_stop(); tick(Q);
        check("rd_byte0", 32'(b), 32'h5A);
        check("rd_byte1", 32'(b2), 32'hC3);
        check("rd_tx_ready_pulses", 32'(txr_cnt), 32'd2);

        // Write 0x11, repeated START, read 0x22; busy must stay high across the turn.
        rx_q.delete(); busy_low = 0;
        send_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        check("rs_wr_addr_ack", 32'(ack), 32'(I2C_ACK));
        busy_watch = 1'b1;
        write_byte(8'h11, ack);
        check("rs_wr_data_ack", 32'(ack), 32'(I2C_ACK));
        tx_data = 8'h22;
        send_start();
        write_byte({MY_ADDR, 1'b1}, ack);
        check("rs_rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        read_byte(b);
        write_bit(I2C_NACK);
        busy_watch = 1'b0;
        send_stop(); tick(Q);
        check("rs_rx_byte", 32'(rx_at(0)), 32'h11);
        check("rs_rd_byte", 32'(b), 32'h22);
        check("rs_busy_low_cycles", 32'(busy_low), 32'd0);

        // Read with no tx byte available for 40 cycles after the address ACK.
        tx_valid = 1'b0; txr_cnt = 0;
        send_start();
        write_byte({MY_ADDR, 1'b1}, ack);
        check("st_addr_ack", 32'(ack), 32'(I2C_ACK));
        scl_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (scl_oe === 1'b1) scl_cnt++;
        end
        check("st_scl_hold_cycles", 32'(scl_cnt), STRETCH ? 32'd40 : 32'd0);
        tx_data = 8'h96; tx_valid = 1'b1; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("st_tx_ready_seen", 32'(seen), 32'(STRETCH));
        tick(2);
        check("st_scl_released", 32'(scl_oe), 32'd0);
        read_byte(b);
        write_bit(I2C_NACK);
        send_stop(); tick(Q);
        check("st_bus_byte", 32'(b), STRETCH ? 32'h96 : 32'hFF);
        check("st_tx_ready_count", 32'(txr_cnt), 32'(STRETCH));

        // Asynchronous reset during bit 4 of a write data byte 0xB6.
        rx_q.delete();
        send_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        check("ar_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        sda_m = 1'b1;
        tick(Q); raise_scl(); tick(2);
        check("ar_busy_before", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_sda_oe_async", 32'(sda_oe), 32'd0);
        check("ar_busy_async", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        read_bit(ack);
        check("ar_ignored_ack", 32'(ack), 32'(I2C_NACK));
        send_stop(); tick(Q);
        check("ar_ignored_rx", 32'(rx_q.size()), 32'd0);
        send_start();
        write_byte({MY_ADDR, 1'b0}, ack);
        check("ar_fresh_addr_ack", 32'(ack), 32'(I2C_ACK));
        write_byte(8'h77, ack);
        check("ar_fresh_data_ack", 32'(ack), 32'(I2C_ACK));
        send_stop(); tick(Q);
        check("ar_fresh_rx", 32'(rx_at(0)), 32'h77);
        check("ar_fresh_rx_count", 32'(rx_q.size()), 32'd1);

        // Randomized transactions against the transaction-level expectation.
        for (int t = 0; t < 8; t++) begin
            a = MY_ADDR;
            if ($urandom_range(0, 3) == 0) begin
                do a = 7'($urandom); while (a == MY_ADDR);
            end
            match = (a == MY_ADDR);
            rw    = 1'($urandom_range(0, 1));
            n     = int'($urandom_range(1, 3));
            for (int k = 0; k < 3; k++) dat[k] = 8'($urandom);
            rx_q.delete(); txr_cnt = 0;
            tx_data = dat[0]; tx_valid = 1'b1;
            send_start();
            write_byte({a, rw}, ack);
            check("rnd_addr_ack", 32'(ack), match ? 32'(I2C_ACK) : 32'(I2C_NACK));
            if (!rw) begin
                for (int k = 0; k < n; k++) begin
                    write_byte(dat[k], ack);
                    check("rnd_wr_ack", 32'(ack), match ? 32'(I2C_ACK) : 32'(I2C_NACK));
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    read_byte(b);
                    check("rnd_rd_byte", 32'(b), match ? 32'(dat[k]) : 32'hFF);
                    if (k + 1 < n) begin
                        tx_data = dat[k+1];
                        write_bit(I2C_ACK);
                    end else begin
                        write_bit(I2C_NACK);
                    end
                end
            end
            send_stop(); tick(Q);
            exp_n = (match && !rw) ? n : 0;
            check("rnd_rx_count", 32'(rx_q.size()), 32'(exp_n));
            for (int k = 0; k < exp_n; k++) check("rnd_rx_byte", 32'(rx_at(k)), 32'(dat[k]));
            check("rnd_tx_ready_count", 32'(txr_cnt), (match && rw) ? 32'(n) : 32'd0);
            check("rnd_busy_idle", 32'(busy), 32'd0);
        end

        check("sda_change_while_scl_high", 32'(oe_glitch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
